// File: rtl/bitmap_bound_alu.sv
// Margin and 2x-scale finder for a COLS x ROWS glyph bitmap fed as one column stream and two opposing row streams.
// Define BOUND_ALU_PACK_EN to add the 16-bit legacy packed result port.
module bitmap_bound_alu #(
  parameter  int COLS      = 24,
  parameter  int ROWS      = 64,
  parameter  int HSCALE_TH = 12,
  parameter  int VSCALE_TH = 32,
  localparam int CW        = $clog2(COLS + 1),
  localparam int RW        = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            col_valid,
  output logic            col_ready,
  input  logic [ROWS-1:0] col_data,
  input  logic            col_last,
  input  logic            top_valid,
  output logic            top_ready,
  input  logic [COLS-1:0] top_data,
  input  logic            bot_valid,
  output logic            bot_ready,
  input  logic [COLS-1:0] bot_data,
  output logic [CW-1:0]   lshift,
  output logic [CW-1:0]   rshift,
  output logic [RW-1:0]   ushift,
  output logic [RW-1:0]   dshift,
  output logic            hscale,
  output logic            vscale,
  output logic            empty,
  output logic            err,
  output logic            busy,
  output logic            done
`ifdef BOUND_ALU_PACK_EN
  ,
  output logic [15:0]     result
`endif
);

  localparam logic [CW-1:0] COL_LAST_IDX = CW'(COLS - 1);
  localparam logic [RW:0]   ROWS_W       = (RW+1)'(ROWS);
  localparam logic [RW:0]   ROWS_M2      = (RW+1)'(ROWS - 2);
  localparam logic [CW:0]   HTH          = (CW+1)'(HSCALE_TH);
  localparam logic [RW:0]   VTH          = (RW+1)'(VSCALE_TH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_nxt;

  logic [CW-1:0] col_cnt;
  logic [CW-1:0] lcnt;
  logic [CW-1:0] run;
  logic          lfound;
  logic          col_end;
  logic [RW-1:0] ucnt;
  logic [RW-1:0] dcnt;
  logic          tfound;
  logic          bfound;

  logic          scan;
  logic [RW:0]   row_sum;
  logic          col_acc, top_acc, bot_acc;
  logic          col_fin_beat;
  logic          rows_fin, all_fin;
  logic [CW-1:0] rsh_cur;
  logic [CW:0]   hsum;

  assign scan     = (state == SCAN);
  assign busy     = scan;
  assign done     = (state == DONE);
  assign row_sum  = {1'b0, ucnt} + {1'b0, dcnt};

  assign col_ready = scan && !col_end;
  assign top_ready = scan && !tfound && (row_sum < ROWS_W);
  // While the top stream is still searching, the bottom stream yields the last two rows
  // so the shared tie always resolves on the top side and the sum can never pass ROWS.
  assign bot_ready = scan && !bfound && (row_sum < ROWS_W) && (tfound || (row_sum < ROWS_M2));

  assign col_acc = col_valid && col_ready && !start;
  assign top_acc = top_valid && top_ready && !start;
  assign bot_acc = bot_valid && bot_ready && !start;

  assign col_fin_beat = col_last || (col_cnt == COL_LAST_IDX);
  assign rows_fin     = (tfound || (row_sum == ROWS_W)) && (bfound || (row_sum == ROWS_W));
  assign all_fin      = col_end && rows_fin;

  assign rsh_cur = lfound ? run : '0;
  assign hsum    = {1'b0, lcnt} + {1'b0, rsh_cur};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = SCAN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SCAN:    if (all_fin) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      lcnt    <= '0;
      run     <= '0;
      lfound  <= 1'b0;
      col_end <= 1'b0;
      ucnt    <= '0;
      dcnt    <= '0;
      tfound  <= 1'b0;
      bfound  <= 1'b0;
      err     <= 1'b0;
      lshift  <= '0;
      rshift  <= '0;
      ushift  <= '0;
      dshift  <= '0;
      hscale  <= 1'b0;
      vscale  <= 1'b0;
      empty   <= 1'b0;
    end else if (start) begin
      col_cnt <= '0;
      lcnt    <= '0;
      run     <= '0;
      lfound  <= 1'b0;
      col_end <= 1'b0;
      ucnt    <= '0;
      dcnt    <= '0;
      tfound  <= 1'b0;
      bfound  <= 1'b0;
      err     <= 1'b0;
      lshift  <= '0;
      rshift  <= '0;
      ushift  <= '0;
      dshift  <= '0;
      hscale  <= 1'b0;
      vscale  <= 1'b0;
      empty   <= 1'b0;
    end else if (scan) begin
      if (col_acc) begin
        col_cnt <= col_cnt + 1'b1;
        if (col_data == '0) begin
          run <= run + 1'b1;
          if (!lfound) lcnt <= lcnt + 1'b1;
        end else begin
          lfound <= 1'b1;
          run    <= '0;
        end
        if (col_fin_beat) begin
          col_end <= 1'b1;
          // A short frame and a missing col_last are both length errors.
          if (col_last != (col_cnt == COL_LAST_IDX)) err <= 1'b1;
        end
      end
      if (top_acc) begin
        if (top_data == '0) ucnt   <= ucnt + 1'b1;
        else                tfound <= 1'b1;
      end
      if (bot_acc) begin
        if (bot_data == '0) dcnt   <= dcnt + 1'b1;
        else                bfound <= 1'b1;
      end
      if (all_fin) begin
        lshift <= lcnt;
        rshift <= rsh_cur;
        ushift <= ucnt;
        dshift <= dcnt;
        hscale <= (hsum >= HTH);
        vscale <= (row_sum >= VTH);
        empty  <= !lfound || (row_sum == ROWS_W);
      end
    end
  end

`ifdef BOUND_ALU_PACK_EN
  assign result = done ? {3'b000, vscale, hscale, 6'(dshift), 5'(lshift)} : 16'h0000;
`endif

endmodule

// File: tb/tb_bitmap_bound_alu.sv
// Directed bench for bitmap_bound_alu: stream drivers with optional stalls, expected margins
// computed from the bitmap and queued at frame launch, compared when done rises.
module tb_bitmap_bound_alu;
  localparam int COLS = 24;
  localparam int ROWS = 64;
  localparam int CW   = 5;
  localparam int RW   = 7;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            col_valid = 1'b0;
  logic            col_ready;
  logic [ROWS-1:0] col_data = '0;
  logic            col_last = 1'b0;
  logic            top_valid = 1'b0;
  logic            top_ready;
  logic [COLS-1:0] top_data = '0;
  logic            bot_valid = 1'b0;
  logic            bot_ready;
  logic [COLS-1:0] bot_data = '0;
  logic [CW-1:0]   lshift, rshift;
  logic [RW-1:0]   ushift, dshift;
  logic            hscale, vscale, empty, err, busy, done;
`ifdef BOUND_ALU_PACK_EN
  logic [15:0]     result;
`endif

  bitmap_bound_alu dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
    .top_valid(top_valid), .top_ready(top_ready), .top_data(top_data),
    .bot_valid(bot_valid), .bot_ready(bot_ready), .bot_data(bot_data),
    .lshift(lshift), .rshift(rshift), .ushift(ushift), .dshift(dshift),
    .hscale(hscale), .vscale(vscale), .empty(empty), .err(err),
    .busy(busy), .done(done)
`ifdef BOUND_ALU_PACK_EN
    , .result(result)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int l, r, u, d;
    bit hs, vs, em, er;
  } exp_t;

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  logic [ROWS-1:0] bm [COLS];
  int              cyc = 0;
  int              last_acc = 0;
  int              done_cyc = -1;
  bit              done_d = 1'b0;
  int              top_acc = 0;
  int              bot_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && !start) begin
      if (col_valid && col_ready) last_acc = cyc + 1;
      if (top_valid && top_ready) begin top_acc++; last_acc = cyc + 1; end
      if (bot_valid && bot_ready) begin bot_acc++; last_acc = cyc + 1; end
    end
    if (done && !done_d) done_cyc = cyc;
    done_d = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [COLS-1:0] rowv(int r);
    logic [COLS-1:0] v;
    for (int c = 0; c < COLS; c++) v[c] = bm[c][r];
    return v;
  endfunction

  task automatic fill(int lc, int rc, int ur, int dr);
    for (int c = 0; c < COLS; c++) bm[c] = '0;
    bm[lc][ur] = 1'b1;
    bm[rc][dr] = 1'b1;
    bm[(lc + rc) / 2][(ur + dr) / 2] = 1'b1;
  endtask

  function automatic exp_t model(int lastb);
    exp_t e;
    int   nb = (lastb < COLS) ? lastb : COLS;
    bit   lf = 1'b0;
    int   run = 0, l = 0, u = 0, d = 0;
    for (int c = 0; c < nb; c++) begin
      if (bm[c] == '0) begin run++; if (!lf) l++; end
      else begin lf = 1'b1; run = 0; end
    end
    while (u < ROWS && rowv(u) == '0) u++;
    if (u == ROWS) begin
      // All rows blank: both streams advance together until two rows remain, then top takes them.
      u = 0;
      while (u + d < ROWS) begin
        if (u + d < ROWS - 2) begin u++; d++; end
        else u++;
      end
    end else begin
      while (rowv(ROWS - 1 - d) == '0) d++;
    end
    e.l  = l;
    e.r  = lf ? run : 0;
    e.u  = u;
    e.d  = d;
    e.hs = (e.l + e.r) >= 12;
    e.vs = (u + d) >= 32;
    e.em = !lf || (u + d == ROWS);
    e.er = (lastb != COLS);
    return e;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic col_drive(int lastb, bit stall);
    int nb = (lastb < COLS) ? lastb : COLS;
    for (int i = 0; i < nb; i++) begin
      if (stall) begin
        col_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      col_valid = 1'b1;
      col_data  = bm[i];
      col_last  = (i + 1 == lastb);
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (col_ready) break;
      end
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    col_last  = 1'b0;
    col_data  = '0;
  endtask

  task automatic row_drive(bit is_top, bit stall);
    bit got;
    for (int k = 0; k < ROWS; k++) begin
      if (stall) begin
        if (is_top) top_valid = 1'b0; else bot_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (is_top) begin top_valid = 1'b1; top_data = rowv(k); end
      else begin bot_valid = 1'b1; bot_data = rowv(ROWS - 1 - k); end
      got = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (done) break;
        if (is_top ? top_ready : bot_ready) begin got = 1'b1; break; end
      end
      if (!got) break;
      @(posedge clk); #1;
    end
    if (is_top) top_valid = 1'b0; else bot_valid = 1'b0;
  endtask

  task automatic check_frame(string nm);
    exp_t e;
    chk({nm, ".sb_nonempty"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({nm, ".done"},    done, 1);
    chk({nm, ".latency"}, done_cyc - last_acc, 1);
    chk({nm, ".lshift"},  lshift, e.l);
    chk({nm, ".rshift"},  rshift, e.r);
    chk({nm, ".ushift"},  ushift, e.u);
    chk({nm, ".dshift"},  dshift, e.d);
    chk({nm, ".hscale"},  hscale, e.hs);
    chk({nm, ".vscale"},  vscale, e.vs);
    chk({nm, ".empty"},   empty,  e.em);
    chk({nm, ".err"},     err,    e.er);
    chk({nm, ".busy"},    busy,   0);
`ifdef BOUND_ALU_PACK_EN
    chk({nm, ".result"}, result, {3'b000, e.vs, e.hs, 6'(e.d), 5'(e.l)});
`endif
  endtask

  task automatic run_frame(int lastb, bit stall, string nm);
    sb.push_back(model(lastb));
    pulse_start();
    top_acc = 0;
    bot_acc = 0;
    fork
      col_drive(lastb, stall);
      row_drive(1'b1, stall);
      row_drive(1'b0, stall);
    join
    @(posedge clk); #1;
    check_frame(nm);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #3;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.col_ready", col_ready, 0);
    chk("rst.top_ready", top_ready, 0);
    chk("rst.bot_ready", bot_ready, 0);
    chk("rst.lshift", lshift, 0);
    chk("rst.err", err, 0);
`ifdef BOUND_ALU_PACK_EN
    chk("rst.result", result, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle.busy", busy, 0);
    chk("idle.col_ready", col_ready, 0);

    // Margins 5/4 horizontally, 10/14 vertically, no stalls.
    fill(5, 19, 10, 49);
    run_frame(24, 1'b0, "t1");

    // Both scale thresholds crossed, with random stalls.
    fill(8, 15, 20, 43);
    run_frame(24, 1'b1, "t2");

    // Blank bitmap: row streams meet and top takes the tie.
    for (int c = 0; c < COLS; c++) bm[c] = '0;
    run_frame(24, 1'b0, "t3");
    chk("t3.top_acc", top_acc, 33);
    chk("t3.bot_acc", bot_acc, 31);

    // Early col_last on beat 20.
    fill(5, 15, 10, 49);
    run_frame(20, 1'b1, "t4");

    // Restart after 7 beats of a discarded frame.
    fill(5, 19, 10, 49);
    pulse_start();
    col_valid = 1'b1; top_valid = 1'b1; bot_valid = 1'b1;
    top_data = '0; bot_data = '0;
    for (int i = 0; i < 7; i++) begin
      col_data = bm[i];
      @(posedge clk); #1;
    end
    col_valid = 1'b0; top_valid = 1'b0; bot_valid = 1'b0;
    chk("t5.busy_mid", busy, 1);
    chk("t5.done_mid", done, 0);
    fill(3, 20, 5, 60);
    run_frame(24, 1'b1, "t5");

    // Asynchronous reset mid-scan after an early col_last has set err.
    pulse_start();
    col_valid = 1'b1; col_data = '0; col_last = 1'b1;
    top_valid = 1'b1; top_data = '0;
    @(posedge clk); #1;
    col_valid = 1'b0; col_last = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6.err_before_rst", err, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst.err", err, 0);
    chk("t6.rst.busy", busy, 0);
    chk("t6.rst.col_ready", col_ready, 0);
    chk("t6.rst.top_ready", top_ready, 0);
    chk("t6.rst.bot_ready", bot_ready, 0);
    top_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("t6.idle.busy", busy, 0);
    chk("t6.idle.done", done, 0);
    chk("t6.idle.top_ready", top_ready, 0);
    // Sums land exactly on both thresholds.
    fill(5, 16, 22, 53);
    run_frame(24, 1'b1, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
